truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
- Stimulus-and-capture stage wrapped around a 3-input combinational function block.
- Drives the block's A/B/C inputs upstream through all 8 combinations, 000 to 111.
- Samples the block's Y output back after a settle interval and assembles an 8-bit truth table.
- Compares the table against an expected mask and reports pass/fail plus the first failing index. This gives the lab a self-checking hardware harness.

Parameters:
- SETTLE, 1, cycles abc_out is held before y_in is sampled; legal range 1..15.
- EXPECTED, 8'hC0, expected truth table; bit i = Y for {A,B,C}=i. The default matches Y = A·B.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; sampled in IDLE or DONE only.
- y_in  in  1  Y from the function block under test.
- abc_out  out  3  {A,B,C} driven to the function block; bit2=A, bit1=B, bit0=C.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high while in DONE; results valid.
- table_out  out  8  captured truth table; bit i = y_in sampled while abc_out==i.
- pass  out  1  table_out==EXPECTED; valid only when done=1.
- fail_idx  out  3  lowest i where table_out[i]!=EXPECTED[i]; 0 when pass=1.

Behaviour:
- States: IDLE, WAIT, DONE.
- Reset (async, immediate, any state):
  - state=IDLE; abc_out=0, busy=0, done=0, table_out=0, pass=0, fail_idx=0.
  - Internal index idx=0, settle count cnt=0.
- IDLE:
  - start=1 at edge k → state=WAIT, idx=0, abc_out=0, cnt=SETTLE-1, table_out=0, busy=1.
- WAIT:
  - cnt!=0: decrement cnt; abc_out held.
  - cnt==0: capture table_out[idx]<=y_in at this edge.
    - idx!=7: idx<=idx+1, abc_out<=idx+1, cnt<=SETTLE-1.
    - idx==7: state=DONE, busy=0, done=1; pass and fail_idx registered the same edge from the final table including bit 7.
  - start ignored while in WAIT.
- Timing:
  - Sample for vector i occurs at edge k+(i+1)·SETTLE.
  - done rises after edge k+8·SETTLE.
  - SETTLE=1 gives 8 cycles of busy.
- DONE:
  - Holds table_out, pass, fail_idx, done=1; abc_out holds 7.
  - start=1 → restart exactly as from IDLE (done drops, table cleared) on that edge.
- fail_idx: priority encode of (table_out ^ EXPECTED), lowest set bit; 0 if none.
- Width rules:
  - idx is 3 bits; never wraps in operation because the sweep ends at 7.
  - cnt is 4 bits.
  - SETTLE outside 1..15 must trip an elaboration-time assertion.
- Reset mid-sweep aborts with no partial results retained; outputs return to reset values.
- y_in is treated as synchronous; a combinational block path fits in one cycle. No synchronizer.

Decomposition:
- Package tt_pkg:
  - state enum tt_state_e {IDLE, WAIT, DONE}.
  - N_VEC=8, IDX_W=3, CNT_W=4.
  - Function first_mismatch(logic [7:0]) returning the lowest-set index.
- Sub-module settle_timer:
  - Loadable down-counter, CNT_W bits.
  - Ports: clk, reset, load, load_val, zero.
  - Keeps the FSM free of counter arithmetic.
- Top-level integration: truth_table_sweeper plus the existing functionABC instance, wired abc_out→A/B/C and Y→y_in.

Test Plan:
- Reset, then start pulse with functionABC attached, SETTLE=1:
  - abc_out steps 0..7 on consecutive cycles.
  - done after 8 busy cycles; table_out=8'hC0, pass=1, fail_idx=0.
- SETTLE=3, same DUT: each abc value held 3 cycles; done 24 cycles after start; table_out=8'hC0.
- Replace y_in with a model of Y=A (expected 8'hF0), EXPECTED=8'hC0: table_out=8'hF0, pass=0, fail_idx=4.
- Assert start continuously during the sweep: no restart, sweep completes normally.
- Start again from DONE: restarts and done drops. Separately, assert reset at abc_out=5: all outputs 0 immediately and state=IDLE.
- Tie y_in=0, EXPECTED=8'h00: pass=1. Then EXPECTED=8'h01: pass=0, fail_idx=0.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types, widths and helpers for the truth-table sweeper.
package tt_pkg;

    localparam int unsigned N_VEC = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } tt_state_e;

    // Lowest set bit index of a mismatch vector; 0 when no bit is set.
    function automatic logic [IDX_W-1:0] first_mismatch(input logic [N_VEC-1:0] diff);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_VEC - 1; i >= 0; i--) begin
            if (diff[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that paces how long each input vector is held.
// Ports: clk, reset (async, active-high), load/load_val (reload), zero (count reached 0).
module settle_timer
    import tt_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps {A,B,C} through 000..111, samples Y after a settle interval, builds
// an 8-bit truth table and compares it with EXPECTED.
// Ports: clk, reset (async, active-high), start, y_in (Y from block under test);
//        abc_out (A=bit2), busy, done, table_out, pass, fail_idx.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int unsigned          SETTLE   = 1,
    parameter logic [N_VEC-1:0]     EXPECTED = 8'hC0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             y_in,
    output logic [IDX_W-1:0] abc_out,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] table_out,
    output logic             pass,
    output logic [IDX_W-1:0] fail_idx
);

    // The settle counter is only CNT_W bits wide.
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("truth_table_sweeper: SETTLE must be in 1..15");
    end

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

    tt_state_e        state_q;
    logic [IDX_W-1:0] idx_q;
    logic             zero_c;
    logic             start_ok_c;
    logic             last_c;
    logic             load_c;
    logic [N_VEC-1:0] captured_c;

    // A start is honoured only outside an active sweep.
    assign start_ok_c = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_c     = (idx_q == IDX_W'(N_VEC - 1));
    assign load_c     = start_ok_c || ((state_q == WAIT) && zero_c && !last_c);

    // Table as it will look after this edge's capture, so the final verdict
    // already includes bit 7.
    always_comb begin
        captured_c        = table_out;
        captured_c[idx_q] = y_in;
    end

    settle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_c),
        .load_val (RELOAD),
        .zero     (zero_c)
    );

    // Sweep control with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
            pass      <= 1'b0;
            fail_idx  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= WAIT;
                        idx_q     <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        table_out <= '0;
                        pass      <= 1'b0;
                        fail_idx  <= '0;
                    end
                end
                WAIT: begin
                    if (zero_c) begin
                        table_out <= captured_c;
                        if (!last_c) begin
                            idx_q <= idx_q + IDX_W'(1);
                        end else begin
                            state_q  <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= (captured_c == EXPECTED);
                            fail_idx <= first_mismatch(captured_c ^ EXPECTED);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The vector index itself drives the block under test.
    assign abc_out = idx_q;

endmodule
